// File: rtl/issue_hazard_unit_pkg.sv
// Shared definitions for the issue stage: instruction field positions,
// class/opcode codes, FSM state encoding and the scoreboard entry format.
//
// Opcode sub-decoding used by the issue stage:
//   TYPE_MEM : opcode[4:3] 00 cargar, 01 guardar, 10 cargar vector, 11 guardar vector
//   TYPE_DATA: opcode 00101..00111 are software stalls; otherwise opcode[4]=1 means immediate form
//   TYPE_VEC : opcode[4]=1 means immediate form; in register form opcode[3]=1 makes rs2 scalar
package issue_pkg;

  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 30;
  localparam int OP_MSB   = 29;
  localparam int OP_LSB   = 25;
  localparam int RD_MSB   = 24;
  localparam int RD_LSB   = 20;
  localparam int RS1_MSB  = 19;
  localparam int RS1_LSB  = 15;
  localparam int RS2_MSB  = 14;
  localparam int RS2_LSB  = 10;
  localparam int IMM_MSB  = 9;
  localparam int IMM_LSB  = 0;

  localparam logic [1:0] TYPE_MEM  = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b01;
  localparam logic [1:0] TYPE_CTRL = 2'b10;
  localparam logic [1:0] TYPE_VEC  = 2'b11;

  localparam logic [4:0] OP_STALL    = 5'b00101;
  localparam logic [4:0] OP_STALL_RD = 5'b00110;
  localparam logic [4:0] OP_STALL_WR = 5'b00111;

  localparam logic [1:0] MEM_LD  = 2'b00;
  localparam logic [1:0] MEM_ST  = 2'b01;
  localparam logic [1:0] MEM_VLD = 2'b10;
  localparam logic [1:0] MEM_VST = 2'b11;

  typedef enum logic [1:0] {
    ISSUE  = 2'd0,
    VREAD  = 2'd1,
    VWRITE = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       is_vec;
    logic [4:0] regno;
  } sb_entry_t;

  // Build a register reference; scalar r0 is hardwired so it is never tracked.
  function automatic sb_entry_t reg_ref(input logic en, input logic vec, input logic [4:0] r);
    sb_entry_t e;
    e.valid  = en && (vec || (r != 5'd0));
    e.is_vec = vec;
    e.regno  = r;
    return e;
  endfunction

endpackage

// File: rtl/issue_hazard_unit_if.sv
// Fetch-to-issue handshake: fetch drives instruction and valid, issue returns ready.
interface issue_hazard_unit_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/issue_hazard_unit_scoreboard.sv
// In-flight destination tracker: a PIPE_DEPTH-deep shift register that moves
// every cycle, plus a combined match of three source references against it.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  sb_entry_t ins,
  input  sb_entry_t src_a,
  input  sb_entry_t src_b,
  input  sb_entry_t src_c,
  output logic      hazard
);

  sb_entry_t entries [PIPE_DEPTH];

  function automatic logic hit(input sb_entry_t e, input sb_entry_t s);
    return e.valid && s.valid && (e.is_vec == s.is_vec) && (e.regno == s.regno);
  endfunction

  // Shift one slot per cycle; entry 0 takes whatever was issued this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) entries[i] <= '0;
    end else begin
      entries[0] <= ins;
      for (int i = 1; i < PIPE_DEPTH; i++) entries[i] <= entries[i-1];
    end
  end

  // Any live destination matching any live source is a hazard.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (hit(entries[i], src_a) || hit(entries[i], src_b) || hit(entries[i], src_c))
        hazard = 1'b1;
    end
  end

endmodule

// File: rtl/issue_hazard_unit.sv
// Issue stage between fetch and decoder: hazard-checked issue, stall bubbles,
// and continuation beats for vector memory transfers.
// Optional build macro: ISSUE_PERF_EN adds stall_count/instruction_count.
//
// state  | meaning
// ISSUE  | normal issue; accept when no hazard, otherwise emit 00101 bubble
// VREAD  | vector load burst; emit 00110 beats that re-reserve vector rd
// VWRITE | vector store burst; emit 00111 beats
module issue_hazard_unit
  import issue_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int VLEN_BEATS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  issue_hazard_unit_if.slave        fetch,
  input  logic                      flush,
  output logic [1:0]                instruction_type,
  output logic [4:0]                opcode,
  output logic [4:0]                rd,
  output logic [4:0]                rs1,
  output logic [4:0]                rs2,
  output logic [9:0]                imm,
  output logic                      issue_valid
`ifdef ISSUE_PERF_EN
  ,
  output logic [18:0]               stall_count,
  output logic [18:0]               instruction_count
`endif
);

  localparam int BW = $clog2(VLEN_BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(VLEN_BEATS - 1);

  state_t        state_q, state_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [4:0]    burst_rd_q, burst_rd_d;

  logic [1:0] type_d;
  logic [4:0] op_d, rd_d, rs1_d, rs2_d;
  logic [9:0] imm_d;
  logic       issue_valid_d;
  logic       ready;

  logic [1:0] f_type;
  logic [4:0] f_op, f_rd, f_rs1, f_rs2;
  logic [9:0] f_imm;
  logic       f_sw_stall;

  sb_entry_t src_a, src_b, src_c, dest, ins;
  logic      hazard;

  assign f_type     = fetch.instr[TYPE_MSB:TYPE_LSB];
  assign f_op       = fetch.instr[OP_MSB:OP_LSB];
  assign f_rd       = fetch.instr[RD_MSB:RD_LSB];
  assign f_rs1      = fetch.instr[RS1_MSB:RS1_LSB];
  assign f_rs2      = fetch.instr[RS2_MSB:RS2_LSB];
  assign f_imm      = fetch.instr[IMM_MSB:IMM_LSB];
  assign f_sw_stall = (f_op >= OP_STALL) && (f_op <= OP_STALL_WR);

  assign fetch.instr_ready = ready;

  // Source/destination decode of the presented instruction per class.
  always_comb begin
    src_a = '0;
    src_b = '0;
    src_c = '0;
    dest  = '0;
    case (f_type)
      TYPE_MEM: begin
        src_a = reg_ref(1'b1, 1'b0, f_rs1);
        case (f_op[4:3])
          MEM_LD:  dest  = reg_ref(1'b1, 1'b0, f_rd);
          MEM_ST:  src_c = reg_ref(1'b1, 1'b0, f_rd);
          MEM_VLD: dest  = reg_ref(1'b1, 1'b1, f_rd);
          default: src_c = reg_ref(1'b1, 1'b1, f_rd);
        endcase
      end
      TYPE_DATA: begin
        if (!f_sw_stall) begin
          src_a = reg_ref(1'b1, 1'b0, f_rs1);
          src_b = reg_ref(!f_op[4], 1'b0, f_rs2);
          dest  = reg_ref(1'b1, 1'b0, f_rd);
        end
      end
      TYPE_CTRL: begin
        src_a = reg_ref(1'b1, 1'b0, f_rs1);
        src_b = reg_ref(1'b1, 1'b0, f_rs2);
      end
      default: begin
        src_a = reg_ref(1'b1, 1'b1, f_rs1);
        src_b = reg_ref(!f_op[4], !f_op[3], f_rs2);
        dest  = reg_ref(1'b1, 1'b1, f_rd);
      end
    endcase
  end

  issue_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH)) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .ins    (ins),
    .src_a  (src_a),
    .src_b  (src_b),
    .src_c  (src_c),
    .hazard (hazard)
  );

  // Next state, next output beat and scoreboard insert; flush overrides everything.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    burst_rd_d    = burst_rd_q;
    ready         = 1'b0;
    ins           = '0;
    type_d        = TYPE_DATA;
    op_d          = OP_STALL;
    rd_d          = '0;
    rs1_d         = '0;
    rs2_d         = '0;
    imm_d         = '0;
    issue_valid_d = 1'b0;
    if (flush) begin
      state_d    = ISSUE;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        ISSUE: begin
          ready = !hazard;
          if (fetch.instr_valid && !hazard) begin
            type_d        = f_type;
            op_d          = f_op;
            rd_d          = f_rd;
            rs1_d         = f_rs1;
            rs2_d         = f_rs2;
            imm_d         = f_imm;
            issue_valid_d = 1'b1;
            ins           = dest;
            if ((VLEN_BEATS > 1) && (f_type == TYPE_MEM) && f_op[4]) begin
              state_d    = f_op[3] ? VWRITE : VREAD;
              beat_cnt_d = BW'(1);
              burst_rd_d = f_rd;
            end
          end
        end
        VREAD, VWRITE: begin
          op_d = (state_q == VREAD) ? OP_STALL_RD : OP_STALL_WR;
          rd_d = burst_rd_q;
          if (state_q == VREAD) ins = reg_ref(1'b1, 1'b1, burst_rd_q);
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = ISSUE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
        default: begin
          state_d    = ISSUE;
          beat_cnt_d = '0;
        end
      endcase
    end
  end

  // State and registered decoder-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ISSUE;
      beat_cnt_q       <= '0;
      burst_rd_q       <= '0;
      instruction_type <= TYPE_DATA;
      opcode           <= OP_STALL;
      rd               <= '0;
      rs1              <= '0;
      rs2              <= '0;
      imm              <= '0;
      issue_valid      <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      burst_rd_q       <= burst_rd_d;
      instruction_type <= type_d;
      opcode           <= op_d;
      rd               <= rd_d;
      rs1              <= rs1_d;
      rs2              <= rs2_d;
      imm              <= imm_d;
      issue_valid      <= issue_valid_d;
    end
  end

`ifdef ISSUE_PERF_EN
  // Saturating counts: every beat is either a real issue or an injected one.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count       <= '0;
      instruction_count <= '0;
    end else if (issue_valid_d) begin
      if (instruction_count != '1) instruction_count <= instruction_count + 19'd1;
    end else begin
      if (stall_count != '1) stall_count <= stall_count + 19'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_hazard_unit.sv
// Directed bench for issue_hazard_unit with hand-computed expectations.
module tb_issue_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] instruction_type;
  logic [4:0] opcode, rd, rs1, rs2;
  logic [9:0] imm;
  logic       issue_valid;
`ifdef ISSUE_PERF_EN
  logic [18:0] stall_count, instruction_count;
`endif

  int total = 0;
  int bad   = 0;

  issue_hazard_unit_if fetch ();

  issue_hazard_unit #(.PIPE_DEPTH(3), .VLEN_BEATS(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch            (fetch),
    .flush            (flush),
    .instruction_type (instruction_type),
    .opcode           (opcode),
    .rd               (rd),
    .rs1              (rs1),
    .rs2              (rs2),
    .imm              (imm),
    .issue_valid      (issue_valid)
`ifdef ISSUE_PERF_EN
    ,
    .stall_count      (stall_count),
    .instruction_count(instruction_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [4:0] op,
                                     input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [9:0] im);
    return {t, op, d, s1, s2, im};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    fetch.instr_valid = 1'b0;
    fetch.instr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_bubble(input string tag, input logic [4:0] op);
    chk({tag, "_type"}, instruction_type, 2'b01);
    chk({tag, "_op"}, opcode, op);
    chk({tag, "_iv"}, issue_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    do_reset();
    chk_bubble("rst", 5'b00101);
    chk("rst_rd", rd, 5'd0);
    chk("rst_imm", imm, 10'd0);
    settle();
    chk("rst_ready", fetch.instr_ready, 1'b1);

    // Independent back-to-back stream
    fetch.instr_valid = 1'b1;
    fetch.instr = mk(2'b01, 5'd0, 5'd1, 5'd2, 5'd3, 10'd0);
    settle();
    chk("ind_ready0", fetch.instr_ready, 1'b1);
    tick();
    chk("ind_iv0", issue_valid, 1'b1);
    chk("ind_rd0", rd, 5'd1);
    chk("ind_rs1_0", rs1, 5'd2);
    fetch.instr = mk(2'b01, 5'd0, 5'd4, 5'd5, 5'd6, 10'd0);
    settle();
    chk("ind_ready1", fetch.instr_ready, 1'b1);
    tick();
    chk("ind_iv1", issue_valid, 1'b1);
    chk("ind_rd1", rd, 5'd4);
    chk("ind_rs2_1", rs2, 5'd6);

    // RAW hazard: resta r4,r1,r5 after suma r1,r2,r3
    do_reset();
    fetch.instr_valid = 1'b1;
    fetch.instr = mk(2'b01, 5'd0, 5'd1, 5'd2, 5'd3, 10'd0);
    tick();
    chk("raw_iv_w", issue_valid, 1'b1);
    fetch.instr = mk(2'b01, 5'd1, 5'd4, 5'd1, 5'd5, 10'd0);
    settle();
    chk("raw_ready_pre", fetch.instr_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bubble($sformatf("raw_b%0d", i), 5'b00101);
      settle();
      chk($sformatf("raw_ready%0d", i), fetch.instr_ready, (i == 2) ? 1'b1 : 1'b0);
    end
    tick();
    chk("raw_iv", issue_valid, 1'b1);
    chk("raw_op", opcode, 5'd1);
    chk("raw_rd", rd, 5'd4);
`ifdef ISSUE_PERF_EN
    chk("raw_stalls", stall_count, 19'd3);
    chk("raw_instrs", instruction_count, 19'd2);
`endif

    // Vector load burst into v2
    do_reset();
    fetch.instr_valid = 1'b1;
    fetch.instr = mk(2'b00, 5'b10000, 5'd2, 5'd3, 5'd0, 10'd0);
    tick();
    chk("vld_type", instruction_type, 2'b00);
    chk("vld_op", opcode, 5'b10000);
    chk("vld_iv", issue_valid, 1'b1);
    fetch.instr_valid = 1'b0;
    fetch.instr = '0;
    settle();
    chk("vld_ready_a", fetch.instr_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bubble($sformatf("vld_b%0d", i), 5'b00110);
      chk($sformatf("vld_rd%0d", i), rd, 5'd2);
      settle();
      chk($sformatf("vld_ready%0d", i), fetch.instr_ready, (i == 2) ? 1'b1 : 1'b0);
    end
    tick();
    chk_bubble("vld_after", 5'b00101);
    // Continuation beats keep v2 reserved: a reader of v2 must wait
    fetch.instr_valid = 1'b1;
    fetch.instr = mk(2'b11, 5'd0, 5'd7, 5'd2, 5'd3, 10'd0);
    settle();
    chk("vrd_ready0", fetch.instr_ready, 1'b0);
    tick();
    settle();
    chk("vrd_ready1", fetch.instr_ready, 1'b0);
    tick();
    settle();
    chk("vrd_ready2", fetch.instr_ready, 1'b1);
    tick();
    chk("vrd_iv", issue_valid, 1'b1);
    chk("vrd_type", instruction_type, 2'b11);

    // Vector store burst aborted by flush on the second continuation beat
    do_reset();
    fetch.instr_valid = 1'b1;
    fetch.instr = mk(2'b00, 5'b11000, 5'd4, 5'd3, 5'd0, 10'd0);
    tick();
    chk("vst_op", opcode, 5'b11000);
    fetch.instr_valid = 1'b0;
    fetch.instr = '0;
    tick();
    chk_bubble("vst_b0", 5'b00111);
    flush = 1'b1;
    settle();
    chk("fl_ready", fetch.instr_ready, 1'b0);
    tick();
    chk_bubble("fl_out", 5'b00101);
    flush = 1'b0;
    settle();
    chk("fl_ready_after", fetch.instr_ready, 1'b1);
    tick();
    chk_bubble("fl_next", 5'b00101);

    // r0 never creates a hazard
    do_reset();
    fetch.instr_valid = 1'b1;
    fetch.instr = mk(2'b01, 5'd0, 5'd0, 5'd1, 5'd2, 10'd0);
    tick();
    chk("r0_iv0", issue_valid, 1'b1);
    fetch.instr = mk(2'b01, 5'd0, 5'd3, 5'd0, 5'd0, 10'd0);
    settle();
    chk("r0_ready", fetch.instr_ready, 1'b1);
    tick();
    chk("r0_iv1", issue_valid, 1'b1);
    chk("r0_rd1", rd, 5'd3);

    // Reset in the middle of a vector load burst
    do_reset();
    fetch.instr_valid = 1'b1;
    fetch.instr = mk(2'b00, 5'b10000, 5'd2, 5'd3, 5'd0, 10'd0);
    tick();
    fetch.instr_valid = 1'b0;
    fetch.instr = '0;
    tick();
    chk_bubble("mr_beat", 5'b00110);
    rst = 1'b1;
    tick();
    chk_bubble("mr_out", 5'b00101);
    chk("mr_rd", rd, 5'd0);
    rst = 1'b0;
    fetch.instr_valid = 1'b1;
    fetch.instr = mk(2'b11, 5'd0, 5'd5, 5'd2, 5'd2, 10'd0);
    settle();
    chk("mr_ready", fetch.instr_ready, 1'b1);
    tick();
    chk("mr_iv", issue_valid, 1'b1);
    chk("mr_type", instruction_type, 2'b11);
    fetch.instr_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
